// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared idle levels, default debounce window and counter sizing helper
package io_cond_pkg;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam logic SW_IDLE = 1'b0;
    localparam logic BTN_IDLE = 1'b1;

    function automatic int cnt_width(int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// debounce_bit: 2-flop synchroniser followed by a consecutive-disagreement counter for one input bit
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic s1, s2;
    logic [CW-1:0] cnt;

    // any cycle where the synchronised level agrees with stable restarts the window
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1       <= RESET_VAL;
            s2       <= RESET_VAL;
            stable_o <= RESET_VAL;
            cnt      <= '0;
        end else begin
            s1 <= raw_i;
            s2 <= s1;
            if (s2 == stable_o) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable_o <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronises and debounces switches and buttons; IO_COND_PRESS_PULSE_EN adds a one-cycle press pulse per button
module io_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int NUM_SW          = 10,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] key_i,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] btn_press_o
);
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(SW_IDLE)) u_db (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .raw_i   (sw_i[i]),
            .stable_o(sw_o[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(BTN_IDLE)) u_db (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .raw_i   (key_i[i]),
            .stable_o(btn_o[i])
        );
    end

`ifdef IO_COND_PRESS_PULSE_EN
    logic [NUM_BTN-1:0] btn_prev;

    // buttons are active-low, so a press is a falling edge of the debounced level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_prev <= {NUM_BTN{BTN_IDLE}};
        end else begin
            btn_prev <= btn_o;
        end
    end

    assign btn_press_o = btn_prev & ~btn_o;
`else
    assign btn_press_o = '0;
`endif
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed checks plus a sliding-window debounce model compared every cycle
module tb_io_input_conditioner;
    localparam int D  = 8;
    localparam int NB = 14;
    localparam logic [NB-1:0] IDLE = {4'hF, 10'h000};
`ifdef IO_COND_PRESS_PULSE_EN
    localparam logic PRESS_EN = 1'b1;
`else
    localparam logic PRESS_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] sw_i  = '1;
    logic [3:0] key_i = '0;
    logic [9:0] sw_o;
    logic [3:0] btn_o, btn_press_o;

    int tests = 0;
    int fails = 0;

    io_input_conditioner #(.NUM_SW(10), .NUM_BTN(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sw_i       (sw_i),
        .key_i      (key_i),
        .sw_o       (sw_o),
        .btn_o      (btn_o),
        .btn_press_o(btn_press_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a bit flips when the last D synchronised samples (raw delayed by two edges) all disagree with it.
    logic [NB-1:0] hist [D+2];
    logic [NB-1:0] exp_vec;
    logic [3:0]    exp_press;
    logic [3:0]    prev_btn;
    logic          model_valid = 1'b0;
    int            n_dis;

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < D + 2; k++) hist[k] = IDLE;
            exp_vec     = IDLE;
            exp_press   = '0;
            model_valid = 1'b1;
        end else begin
            prev_btn = exp_vec[13:10];
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {key_i, sw_i};
            for (int b = 0; b < NB; b++) begin
                n_dis = 0;
                for (int k = 2; k <= D + 1; k++) if (hist[k][b] != exp_vec[b]) n_dis++;
                if (n_dis == D) exp_vec[b] = ~exp_vec[b];
            end
            exp_press = PRESS_EN ? (prev_btn & ~exp_vec[13:10]) : 4'h0;
        end
    end

    always @(negedge clk_i) begin
        if (model_valid) begin
            chk("model sw_o", 32'(sw_o), 32'(exp_vec[9:0]));
            chk("model btn_o", 32'(btn_o), 32'(exp_vec[13:10]));
            chk("model btn_press_o", 32'(btn_press_o), 32'(exp_press));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk_out(input string name, input logic [9:0] sw, input logic [3:0] btn, input logic [3:0] press);
        chk({name, " sw_o"}, 32'(sw_o), 32'(sw));
        chk({name, " btn_o"}, 32'(btn_o), 32'(btn));
        chk({name, " btn_press_o"}, 32'(btn_press_o), 32'(press));
    endtask

    initial begin
        // reset held three edges with all inputs away from idle
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_out("reset", 10'h000, 4'hF, 4'h0);
        end
        rst_i = 1'b0;
        step(1);
        chk_out("after reset", 10'h000, 4'hF, 4'h0);
        sw_i  = '0;
        key_i = '1;
        step(12);
        chk_out("idle", 10'h000, 4'hF, 4'h0);

        // single switch rise: output changes on the 10th edge counting the first sampling edge
        sw_i[3] = 1'b1;
        step(9);
        chk_out("sw3 edge9", 10'h000, 4'hF, 4'h0);
        step(1);
        chk_out("sw3 edge10", 10'h008, 4'hF, 4'h0);

        // short low glitch on key 0 is rejected
        key_i[0] = 1'b0;
        step(5);
        key_i[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk_out("glitch", 10'h008, 4'hF, 4'h0);
        end

        // key 2 bounces then settles low
        key_i[2] = 1'b1; step(2);
        key_i[2] = 1'b0; step(2);
        key_i[2] = 1'b1; step(2);
        key_i[2] = 1'b0;
        step(9);
        chk_out("bounce edge9", 10'h008, 4'hF, 4'h0);
        step(1);
        chk_out("bounce edge10", 10'h008, 4'hB, PRESS_EN ? 4'h4 : 4'h0);
        step(1);
        chk_out("press one cycle", 10'h008, 4'hB, 4'h0);
        key_i[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("release no pulse", 32'(btn_press_o), 32'h0);
        end
        chk_out("released", 10'h008, 4'hF, 4'h0);

        // simultaneous changes on two groups
        sw_i[3]  = 1'b0;
        step(12);
        sw_i[0]  = 1'b1;
        key_i[1] = 1'b0;
        step(9);
        chk_out("simul edge9", 10'h000, 4'hF, 4'h0);
        step(1);
        chk_out("simul edge10", 10'h001, 4'hD, PRESS_EN ? 4'h2 : 4'h0);

        // reset in the middle of a count discards it and restarts the full latency
        step(2);
        sw_i[5]  = 1'b1;
        key_i[3] = 1'b0;
        step(7);
        rst_i = 1'b1;
        step(1);
        chk_out("mid reset", 10'h000, 4'hF, 4'h0);
        rst_i = 1'b0;
        step(9);
        chk_out("post reset edge9", 10'h000, 4'hF, 4'h0);
        step(1);
        chk_out("post reset edge10", 10'h021, 4'h5, PRESS_EN ? 4'hA : 4'h0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
